cpu_top_level: RTL and testbench

CPU_TOP_LEVEL -- requirements
Module: cpu_top_level

---
 rtl/cpu_top_level_if.sv | 22 ++
 rtl/cpu_top_level.sv | 153 +++++++++++++++
 tb/tb_cpu_top_level.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_top_level_if.sv
// Instruction-fetch and data-memory bus between the core and its memories.
// The core drives addresses and requests; memory returns the instruction and load data in the same cycle.
interface cpu_top_level_if;
    logic [31:0] Instr_Addr;
    logic [31:0] INSTRUCTION;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;
    logic [31:0] MEM_data;

    modport master (
        output Instr_Addr, MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
        input  INSTRUCTION, MEM_data
    );

    modport slave (
        input  Instr_Addr, MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en,
        output INSTRUCTION, MEM_data
    );
endinterface

// File: rtl/cpu_top_level.sv
// Single-cycle RV32I-subset core.
// Each rising CLK retires the instruction presented at Instr_Addr; unsupported encodings retire as NOPs.
module cpu_top_level (
    input  logic            CLK,
    input  logic            Reset,
    cpu_top_level_if.master bus
);
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0] pc;
    logic [31:0] regs [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = bus.INSTRUCTION;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc + 32'd4;

    // The ALU also forms load/store/JALR addresses: non-ALU opcodes force an add.
    logic [31:0] alu_b, alu_res;
    logic [2:0]  alu_op;
    always_comb begin
        alu_b  = (opcode == OPC_OP) ? rs2_val : ((opcode == OPC_STORE) ? imm_s : imm_i);
        alu_op = (opcode == OPC_OP || opcode == OPC_OP_IMM) ? funct3 : 3'd0;
        case (alu_op)
            3'd0:    alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_res = rs1_val << alu_b[4:0];
            3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_res = {31'd0, rs1_val < alu_b};
            3'd4:    alu_res = rs1_val ^ alu_b;
            3'd5:    alu_res = funct7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'd6:    alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic taken;
    always_comb begin
        case (funct3)
            3'd0:    taken = (rs1_val == rs2_val);
            3'd1:    taken = (rs1_val != rs2_val);
            3'd4:    taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    taken = (rs1_val < rs2_val);
            3'd7:    taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    logic        reg_we, mem_rd, mem_wr;
    logic [31:0] wb_val, pc_next;
    always_comb begin
        reg_we  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        wb_val  = alu_res;
        pc_next = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                reg_we = 1'b1;
                wb_val = imm_u;
            end
            OPC_AUIPC: begin
                reg_we = 1'b1;
                wb_val = pc + imm_u;
            end
            OPC_JAL: begin
                reg_we  = 1'b1;
                wb_val  = pc_plus4;
                pc_next = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'd0) begin
                    reg_we  = 1'b1;
                    wb_val  = pc_plus4;
                    pc_next = {alu_res[31:1], 1'b0};
                end
            end
            OPC_BRANCH: begin
                if (taken) pc_next = pc + imm_b;
            end
            OPC_LOAD: begin
                if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) begin
                    mem_rd = 1'b1;
                    reg_we = 1'b1;
                    wb_val = bus.MEM_data;
                end
            end
            OPC_STORE: begin
                mem_wr = (funct3 < 3'd3);
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'd1)      reg_we = (funct7 == 7'h00);
                else if (funct3 == 3'd5) reg_we = (funct7 == 7'h00 || funct7 == 7'h20);
                else                     reg_we = 1'b1;
            end
            OPC_OP: begin
                reg_we = (funct7 == 7'h00) ||
                         (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
            end
            default: ;
        endcase
    end

    assign bus.Instr_Addr = pc;
    assign bus.MEM_addr   = alu_res;
    assign bus.MEM_WR_out = rs2_val;
    assign bus.MEM_type   = funct3;
    assign bus.MEM_rd_en  = mem_rd & ~Reset;
    assign bus.MEM_wr_en  = mem_wr & ~Reset;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= pc_next;
            if (reg_we && rd != 5'd0) regs[rd] <= wb_val;
        end
    end
endmodule

// File: tb/tb_cpu_top_level.sv
// Bench for cpu_top_level: directed program tables, reset corner cases, and a random
// instruction stream compared against an instruction-level model.
module tb_cpu_top_level;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    cpu_top_level_if bus ();
    cpu_top_level dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    int ntests = 0;
    int nfail  = 0;

    // Data memory seen by the core: 256 bytes, little-endian, addresses wrap.
    logic [7:0] emem [256] = '{default: 8'h00};
    logic [7:0] ea0, ea1, ea2, ea3;
    logic [31:0] ew;
    always_comb begin
        ea0 = bus.MEM_addr[7:0];
        ea1 = ea0 + 8'd1;
        ea2 = ea0 + 8'd2;
        ea3 = ea0 + 8'd3;
        ew  = {emem[ea3], emem[ea2], emem[ea1], emem[ea0]};
        case (bus.MEM_type)
            3'd0:    bus.MEM_data = 32'($signed(ew[7:0]));
            3'd1:    bus.MEM_data = 32'($signed(ew[15:0]));
            3'd4:    bus.MEM_data = {24'd0, ew[7:0]};
            3'd5:    bus.MEM_data = {16'd0, ew[15:0]};
            default: bus.MEM_data = ew;
        endcase
    end
    always @(posedge CLK) begin
        if (bus.MEM_wr_en) begin
            emem[ea0] <= bus.MEM_WR_out[7:0];
            if (bus.MEM_type[1:0] != 2'd0) emem[ea1] <= bus.MEM_WR_out[15:8];
            if (bus.MEM_type[1:0] == 2'd2) begin
                emem[ea2] <= bus.MEM_WR_out[23:16];
                emem[ea3] <= bus.MEM_WR_out[31:24];
            end
        end
    end

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] m, d, o;
        m = imm20; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rd_en;
        logic        wr_en;
        logic [31:0] addr;
        logic [2:0]  mtype;
        logic [31:0] wdata;
    } vec_t;

    // kind: 0 = no memory access, 1 = load, 2 = store
    function automatic vec_t mk(logic [31:0] ins, logic [31:0] pc, int kind,
                                logic [31:0] addr, int mtype, logic [31:0] wdata);
        vec_t v;
        logic [31:0] t;
        t = mtype;
        v.instr = ins; v.pc = pc; v.rd_en = (kind == 1); v.wr_en = (kind == 2);
        v.addr = addr; v.mtype = t[2:0]; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc, input logic rd_en,
                                 input logic wr_en, input logic [31:0] addr,
                                 input logic [2:0] mtype, input logic [31:0] wdata);
        chk({tag, " pc"}, bus.Instr_Addr, pc);
        chk({tag, " rd_en"}, {31'd0, bus.MEM_rd_en}, {31'd0, rd_en});
        chk({tag, " wr_en"}, {31'd0, bus.MEM_wr_en}, {31'd0, wr_en});
        if (rd_en || wr_en) begin
            chk({tag, " addr"}, bus.MEM_addr, addr);
            chk({tag, " type"}, {29'd0, bus.MEM_type}, {29'd0, mtype});
        end
        if (wr_en) chk({tag, " wdata"}, bus.MEM_WR_out, wdata);
    endtask

    // Drive at the falling edge, check 1 ns later, retire at the next rising edge.
    task automatic apply_vec(input vec_t v, input string tag);
        bus.INSTRUCTION = v.instr;
        #1;
        check_outputs(tag, v.pc, v.rd_en, v.wr_en, v.addr, v.mtype, v.wdata);
        @(negedge CLK);
    endtask

    logic [31:0] m_regs [32];
    logic [7:0]  m_mem  [256];
    logic [31:0] m_pc;

    task automatic model_exec(input logic [31:0] ins, output logic e_rd, output logic e_wr,
                              output logic [31:0] e_addr, output logic [2:0] e_type,
                              output logic [31:0] e_wdata);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, sh;
        logic [31:0] a, b, ii, is, ib, ij, nxt, wv, w;
        logic        wb, tk;
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        ii = 32'($signed(ins) >>> 20);
        is = (ii & ~32'd31) | {27'd0, ins[11:7]};
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        sh = ii[4:0];
        nxt = m_pc + 4; wb = 1'b0; wv = 32'd0; tk = 1'b0;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'd0; e_type = f3; e_wdata = 32'd0;
        case (op)
            7'h37: begin wb = 1'b1; wv = ins & 32'hFFFFF000; end
            7'h17: begin wb = 1'b1; wv = m_pc + (ins & 32'hFFFFF000); end
            7'h6F: begin wb = 1'b1; wv = m_pc + 4; nxt = m_pc + ij; end
            7'h67: if (f3 == 3'd0) begin wb = 1'b1; wv = m_pc + 4; nxt = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + ib;
            end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                e_rd = 1'b1; e_addr = a + ii; wb = 1'b1;
                for (int k = 0; k < 4; k++) w[8*k +: 8] = m_mem[8'(e_addr + 32'(k))];
                case (f3)
                    3'd0: wv = 32'($signed(w[7:0]));
                    3'd1: wv = 32'($signed(w[15:0]));
                    3'd4: wv = {24'd0, w[7:0]};
                    3'd5: wv = {16'd0, w[15:0]};
                    default: wv = w;
                endcase
            end
            7'h23: if (f3 <= 3'd2) begin
                e_wr = 1'b1; e_addr = a + is; e_wdata = b;
                for (int k = 0; k < (1 << f3); k++) m_mem[8'(e_addr + 32'(k))] = b[8*k +: 8];
            end
            7'h13: begin
                wb = 1'b1;
                case (f3)
                    3'd0: wv = a + ii;
                    3'd2: wv = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: wv = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: wv = a ^ ii;
                    3'd6: wv = a | ii;
                    3'd7: wv = a & ii;
                    3'd1: begin wb = (f7 == 7'h00); wv = a << sh; end
                    default: begin
                        wb = (f7 == 7'h00 || f7 == 7'h20);
                        wv = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
                    end
                endcase
            end
            7'h33: begin
                wb = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                case (f3)
                    3'd0: wv = (f7 == 7'h20) ? a - b : a + b;
                    3'd1: wv = a << b[4:0];
                    3'd2: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: wv = (a < b) ? 32'd1 : 32'd0;
                    3'd4: wv = a ^ b;
                    3'd5: wv = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: wv = a | b;
                    default: wv = a & b;
                endcase
            end
            default: ;
        endcase
        if (wb && rd != 5'd0) m_regs[rd] = wv;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_instr();
        int rd, r1, r2, f3, sel;
        rd = $urandom_range(0, 7); r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7);
        f3 = $urandom_range(0, 7);
        sel = $urandom_range(0, 15);
        case (sel)
            0:  return enc_u($urandom, rd, 'h37);
            1:  return enc_u($urandom, rd, 'h17);
            2:  return enc_j((int'($urandom_range(0, 2047)) - 1024) * 2, rd);
            3:  return enc_i($urandom, r1, (($urandom_range(0, 3) == 0) ? 1 : 0), rd, 'h67);
            4:  return enc_b((int'($urandom_range(0, 255)) - 128) * 2, r2, r1, f3);
            5:  return enc_i($urandom, r1, f3, rd, 'h03);
            6:  return enc_s($urandom, r2, r1, $urandom_range(0, 3));
            7, 8: begin
                if (f3 == 1 || f3 == 5) begin
                    int sel7;
                    sel7 = $urandom_range(0, 3);
                    return enc_i(((sel7 == 0) ? 0 : (sel7 == 1) ? 'h20 : $urandom_range(0, 127)) * 32
                                 + $urandom_range(0, 31), r1, f3, rd, 'h13);
                end
                return enc_i($urandom, r1, f3, rd, 'h13);
            end
            9, 10: begin
                int sel7;
                sel7 = $urandom_range(0, 4);
                return enc_r((sel7 < 2) ? 0 : (sel7 < 4) ? 'h20 : 1, r2, r1, f3, rd);
            end
            11: return enc_i(int'($urandom_range(0, 4095)) - 2048, r1, 0, rd, 'h13);
            12: return $urandom;
            13: begin
                case ($urandom_range(0, 2))
                    0: return 32'h0000000F;
                    1: return 32'h00000073;
                    default: return 32'h00100073;
                endcase
            end
            default: return enc_s($urandom_range(0, 63), r2, 0, 2);
        endcase
    endfunction

    vec_t tab_a [$];
    vec_t tab_b [$];

    initial begin
        logic [31:0] ins, e_addr, e_wdata, e_pc;
        logic        e_rd, e_wr;
        logic [2:0]  e_type;

        // Main directed program, starting right after reset release.
        tab_a.push_back(mk(enc_i(5, 0, 0, 1, 'h13),   32'h00, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(-3, 0, 0, 2, 'h13),  32'h04, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_r(0, 2, 1, 0, 3),      32'h08, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 3, 0, 2),         32'h0C, 2, 32'h0, 2, 32'd2));
        tab_a.push_back(mk(enc_i('h100, 0, 0, 1, 'h13), 32'h10, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_u('h80000, 2, 'h37),   32'h14, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(1, 2, 0, 2, 'h13),   32'h18, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(4, 2, 1, 2),         32'h1C, 2, 32'h104, 2, 32'h80000001));
        tab_a.push_back(mk(enc_i(4, 1, 2, 3, 'h03),   32'h20, 1, 32'h104, 2, 0));
        tab_a.push_back(mk(enc_i(4, 1, 0, 4, 'h03),   32'h24, 1, 32'h104, 0, 0));
        tab_a.push_back(mk(enc_i(7, 1, 4, 5, 'h03),   32'h28, 1, 32'h107, 4, 0));
        tab_a.push_back(mk(enc_s(0, 3, 0, 2),         32'h2C, 2, 32'h0, 2, 32'h80000001));
        tab_a.push_back(mk(enc_s(0, 4, 0, 2),         32'h30, 2, 32'h0, 2, 32'h00000001));
        tab_a.push_back(mk(enc_s(0, 5, 0, 2),         32'h34, 2, 32'h0, 2, 32'h00000080));
        tab_a.push_back(mk(enc_i(6, 1, 1, 6, 'h03),   32'h38, 1, 32'h106, 1, 0));
        tab_a.push_back(mk(enc_s(0, 6, 0, 2),         32'h3C, 2, 32'h0, 2, 32'hFFFF8000));
        tab_a.push_back(mk(enc_i(-1, 0, 0, 1, 'h13),  32'h40, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(1, 0, 0, 2, 'h13),   32'h44, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_b(8, 2, 1, 4),         32'h48, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_b(8, 2, 1, 6),         32'h50, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_r(0, 2, 1, 3, 3),      32'h54, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_r('h20, 2, 1, 5, 4),   32'h58, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_r(0, 2, 1, 5, 5),      32'h5C, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 3, 0, 2),         32'h60, 2, 32'h0, 2, 32'h00000000));
        tab_a.push_back(mk(enc_s(0, 4, 0, 2),         32'h64, 2, 32'h0, 2, 32'hFFFFFFFF));
        tab_a.push_back(mk(enc_s(0, 5, 0, 2),         32'h68, 2, 32'h0, 2, 32'h7FFFFFFF));
        tab_a.push_back(mk(enc_b(12, 2, 1, 7),        32'h6C, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i('h20, 0, 0, 7, 'h13), 32'h78, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(0, 7, 0, 0, 'h67),   32'h7C, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_j(16, 1),              32'h20, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(1, 1, 0, 0, 'h67),   32'h30, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 1, 0, 2),         32'h24, 2, 32'h0, 2, 32'h00000024));
        tab_a.push_back(mk(enc_i(7, 0, 0, 0, 'h13),   32'h28, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_r(0, 0, 0, 0, 1),      32'h2C, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 1, 0, 2),         32'h30, 2, 32'h0, 2, 32'h00000000));
        tab_a.push_back(mk(32'h0000007F,              32'h34, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_i(3, 0, 0, 6, 'h67),   32'h38, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 6, 0, 2),         32'h02, 2, 32'h0, 2, 32'h0000003C));
        tab_a.push_back(mk(32'h00000073,              32'h06, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(1, 6, 0, 0),         32'h0A, 2, 32'h1, 0, 32'h0000003C));
        tab_a.push_back(mk(enc_i(1, 0, 4, 7, 'h03),   32'h0E, 1, 32'h1, 4, 0));
        tab_a.push_back(mk(enc_s(0, 7, 0, 2),         32'h12, 2, 32'h0, 2, 32'h0000003C));
        tab_a.push_back(mk(enc_b(-22, 0, 7, 1),       32'h16, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_u(1, 2, 'h17),         32'h00, 0, 0, 0, 0));
        tab_a.push_back(mk(enc_s(0, 2, 0, 2),         32'h04, 2, 32'h0, 2, 32'h00001000));

        // After an asynchronous reset: registers read back zero, then PC wrap-around.
        tab_b.push_back(mk(enc_s(0, 2, 0, 2),         32'h00, 2, 32'h0, 2, 32'h0));
        tab_b.push_back(mk(enc_s(0, 6, 0, 2),         32'h04, 2, 32'h0, 2, 32'h0));
        tab_b.push_back(mk(enc_i(-4, 0, 0, 0, 'h67),  32'h08, 0, 0, 0, 0));
        tab_b.push_back(mk(enc_i(0, 0, 0, 0, 'h13),   32'hFFFFFFFC, 0, 0, 0, 0));
        tab_b.push_back(mk(enc_i(0, 0, 0, 0, 'h13),   32'h00, 0, 0, 0, 0));

        // Held in reset with a store presented: no request, PC at zero.
        bus.INSTRUCTION = enc_s(4, 0, 0, 2);
        repeat (2) @(negedge CLK);
        #1;
        check_outputs("in_reset", 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < tab_a.size(); i++) apply_vec(tab_a[i], $sformatf("dir_a[%0d]", i));

        // Reset asserted between edges with a store in flight.
        bus.INSTRUCTION = enc_s(0, 2, 0, 2);
        #1;
        check_outputs("pre_abort", 32'h08, 1'b0, 1'b1, 32'h0, 3'd2, 32'h00001000);
        Reset = 1'b1;
        #1;
        check_outputs("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < tab_b.size(); i++) apply_vec(tab_b[i], $sformatf("dir_b[%0d]", i));

        // Random stream against the instruction-level model.
        Reset = 1'b1;
        bus.INSTRUCTION = 32'h00000013;
        @(negedge CLK);
        for (int i = 0; i < 256; i++) m_mem[i] = emem[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = 32'd0;
        Reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ins = rand_instr();
            bus.INSTRUCTION = ins;
            #1;
            e_pc = m_pc;
            model_exec(ins, e_rd, e_wr, e_addr, e_type, e_wdata);
            check_outputs($sformatf("rnd[%0d] %h", i, ins), e_pc, e_rd, e_wr, e_addr, e_type, e_wdata);
            @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
